// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Owns the data memory unit's single address/data port on behalf of the MEM
//   stage. Stores are queued in a small FIFO and retired one per cycle whenever
//   a load does not need the port. Loads go straight through with zero latency
//   unless they word-alias a queued store, in which case they stall until the
//   aliasing entries have drained.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         MEM stage presents a memory op this cycle
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         unaligned store data
//   req_ctrl          size/sign code forwarded to the memory unit
//   fence             hold the pipeline until the buffer is empty
//   req_ready         op accepted this cycle (0 = stall)
//   load_data         load result, valid with load_valid
//   load_valid        load completed this cycle
//   mem_address       memory unit address
//   mem_write_data    memory unit write data
//   mem_ctrl          memory unit DATAMEMControl
//   mem_write_enable  memory unit write enable
//   mem_read_data     memory unit combinational read data
//   empty             no queued stores
//   count             number of queued stores
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_ctrl,
    input  logic                     fence,
    output logic                     req_ready,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     load_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [2:0]               mem_ctrl,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [2:0]               ctrl_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] offset;

    logic is_load;
    logic is_store;
    logic not_empty;
    logic full;
    logic fence_block;
    logic match_any;
    logic hit;
    logic load_go;
    logic drain;
    logic enq;

    assign is_load     = req_valid & ~req_write;
    assign is_store    = req_valid &  req_write;
    assign not_empty   = (count != '0);
    assign full        = (count == DEPTH_C);
    // fence only holds the pipeline while something is still queued
    assign fence_block = fence & not_empty;

    // Word-granular alias check against every live entry. An entry is live
    // when its distance from head (mod DEPTH) is below count.
    always_comb begin
        match_any = 1'b0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head;
            if (({1'b0, offset} < count) &&
                (addr_q[i][ADDRESS_WIDTH-1:2] == req_addr[ADDRESS_WIDTH-1:2])) begin
                match_any = 1'b1;
            end
        end
    end

    assign hit     = is_load & match_any;
    assign load_go = is_load & ~hit & ~fence_block;
    // the port drains whenever a load is not using it
    assign drain   = ~load_go & not_empty;
    // full check uses the pre-edge count: no same-cycle bypass through a drain
    assign enq     = is_store & ~fence_block & ~full;

    always_comb begin
        if (!req_valid) begin
            req_ready = 1'b1;
        end else if (fence_block) begin
            req_ready = 1'b0;
        end else if (req_write) begin
            req_ready = ~full;
        end else begin
            req_ready = ~hit;
        end
    end

    // port arbitration: load first, then drain, otherwise idle
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_ctrl         = '0;
        mem_write_enable = 1'b0;
        load_data        = '0;
        load_valid       = 1'b0;
        if (load_go) begin
            mem_address = req_addr;
            mem_ctrl    = req_ctrl;
            load_data   = mem_read_data;
            load_valid  = 1'b1;
        end else if (drain) begin
            mem_address      = addr_q[head];
            mem_write_data   = data_q[head];
            mem_ctrl         = ctrl_q[head];
            mem_write_enable = 1'b1;
        end
    end

    // control state: pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // entry payload carries no reset; liveness is defined by head/count
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= req_addr;
            data_q[tail] <= req_wdata;
            ctrl_q[tail] <= req_ctrl;
        end
    end

    assign empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NROWS = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_ctrl;
    logic          fence;
    logic          req_ready;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [2:0]    mem_ctrl;
    logic          mem_write_enable;
    logic [DW-1:0] mem_read_data;
    logic          empty;
    logic [CW-1:0] count;

    store_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ctrl(req_ctrl), .fence(fence),
        .req_ready(req_ready), .load_data(load_data), .load_valid(load_valid),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_ctrl(mem_ctrl), .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    // memory unit behind the port: word array, combinational read
    logic [31:0] dmem    [128];
    logic [31:0] ref_mem [128];
    logic [31:0] wlog [$];

    assign mem_read_data = dmem[mem_address[8:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            dmem[mem_address[8:2]] = mem_write_data;
            wlog.push_back(mem_address);
        end
    end

    // reference model: pending stores as a plain queue
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } st_t;
    st_t q[$];

    typedef struct packed {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
        logic        f;
        logic        rdy;
        logic        lv;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ld;
        logic [2:0]  cnt;
    } vec_t;
    vec_t tbl [NROWS];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] c, input logic f);
        vec_t x;
        x   = '0;
        x.v = v; x.w = w; x.a = a; x.d = d; x.c = c; x.f = f;
        return x;
    endfunction

    // One cycle: drive at posedge+1, check model (and table row if row>=0)
    // at posedge+4, then advance the model across the clock edge.
    task automatic step(input vec_t x, input int row);
        int   n;
        logic fb, hit, lgo, drn, enq, rdy;
        st_t  e;
        req_valid = x.v; req_write = x.w; req_addr = x.a;
        req_wdata = x.d; req_ctrl = x.c; fence = x.f;
        #3;
        n   = q.size();
        fb  = x.f && (n > 0);
        hit = 1'b0;
        foreach (q[i]) if (x.v && !x.w && (q[i].addr[31:2] == x.a[31:2])) hit = 1'b1;
        lgo = x.v && !x.w && !hit && !fb;
        drn = !lgo && (n > 0);
        enq = x.v && x.w && !fb && (n < DEPTH);
        rdy = !x.v ? 1'b1 : fb ? 1'b0 : x.w ? (n < DEPTH) : !hit;
        chk("req_ready", req_ready, rdy);
        chk("load_valid", load_valid, lgo);
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("mem_write_enable", mem_write_enable, drn);
        if (lgo) begin
            chk("load_addr", mem_address, x.a);
            chk("load_ctrl", mem_ctrl, x.c);
            chk("load_data", load_data, ref_mem[x.a[8:2]]);
        end else if (drn) begin
            chk("drain_addr", mem_address, q[0].addr);
            chk("drain_data", mem_write_data, q[0].data);
            chk("drain_ctrl", mem_ctrl, q[0].ctrl);
        end else begin
            chk("idle_addr", mem_address, 0);
        end
        if (row >= 0) begin
            chk($sformatf("row%0d_ready", row), req_ready, x.rdy);
            chk($sformatf("row%0d_lvalid", row), load_valid, x.lv);
            chk($sformatf("row%0d_wen", row), mem_write_enable, x.we);
            chk($sformatf("row%0d_maddr", row), mem_address, x.maddr);
            chk($sformatf("row%0d_count", row), count, x.cnt);
            if (x.we) chk($sformatf("row%0d_wdata", row), mem_write_data, x.mwd);
            if (x.lv) chk($sformatf("row%0d_ldata", row), load_data, x.ld);
        end
        @(posedge clk);
        if (drn) begin
            e = q.pop_front();
            ref_mem[e.addr[8:2]] = e.data;
        end
        if (enq) q.push_back('{addr: x.a, data: x.d, ctrl: x.c});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0), -1);
    endtask

    initial begin
        int mark;
        vec_t x;

        // fields: v w addr wdata ctrl fence | ready lvalid wen maddr wdata ldata count
        tbl[0]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF,3'd2,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[1]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b1,32'h10,32'hDEADBEEF,32'h0,       3'd1};
        tbl[2]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[3]  = '{1'b1,1'b1,32'h20,32'h11223344,3'd2,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[4]  = '{1'b1,1'b0,32'h22,32'h0,       3'd0,1'b0, 1'b0,1'b0,1'b1,32'h20,32'h11223344,32'h0,       3'd1};
        tbl[5]  = '{1'b1,1'b0,32'h22,32'h0,       3'd0,1'b0, 1'b1,1'b1,1'b0,32'h22,32'h0,       32'h11223344,3'd0};
        tbl[6]  = '{1'b1,1'b1,32'h30,32'h0000A5A5,3'd2,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[7]  = '{1'b1,1'b0,32'h40,32'h0,       3'd2,1'b0, 1'b1,1'b1,1'b0,32'h40,32'h0,       32'hC0DE0010,3'd1};
        tbl[8]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b1,32'h30,32'h0000A5A5,32'h0,       3'd1};
        tbl[9]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[10] = '{1'b1,1'b1,32'h44,32'h00000055,3'd2,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[11] = '{1'b1,1'b1,32'h48,32'h00000066,3'd2,1'b1, 1'b0,1'b0,1'b1,32'h44,32'h00000055,32'h0,       3'd1};
        tbl[12] = '{1'b1,1'b1,32'h48,32'h00000066,3'd2,1'b1, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};
        tbl[13] = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b1,32'h48,32'h00000066,32'h0,       3'd1};
        tbl[14] = '{1'b0,1'b0,32'h0, 32'h0,       3'd0,1'b0, 1'b1,1'b0,1'b0,32'h0, 32'h0,       32'h0,       3'd0};

        for (int i = 0; i < 128; i++) begin
            dmem[i]    = 32'hC0DE0000 + i;
            ref_mem[i] = 32'hC0DE0000 + i;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_ctrl = '0; fence = 1'b0;
        #12;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_wen", mem_write_enable, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_maddr", mem_address, 0);
        chk("reset_lvalid", load_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int r = 0; r < NROWS; r++) step(tbl[r], r);

        // stores to 0x0..0x10 interleaved with loads to 0x100; writes in order
        mark = wlog.size();
        for (int k = 0; k < 5; k++) begin
            step(mk(1'b1, 1'b1, 32'(4 * k), 32'h1000 + k, 3'd2, 1'b0), -1);
            step(mk(1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 1'b0), -1);
        end
        idle(3);
        chk("order_count", wlog.size() - mark, 5);
        for (int k = 0; k < 5; k++) begin
            if (mark + k < wlog.size()) chk($sformatf("order_addr%0d", k), wlog[mark + k], 4 * k);
            chk($sformatf("order_word%0d", k), dmem[k], 32'h1000 + k);
        end

        // asynchronous reset with a drain in flight
        step(mk(1'b1, 1'b1, 32'h50, 32'hAAAA0050, 3'd2, 1'b0), -1);
        step(mk(1'b1, 1'b1, 32'h54, 32'hAAAA0054, 3'd2, 1'b0), -1);
        x = mk(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        req_valid = 1'b0; req_write = 1'b0; fence = 1'b0;
        #2;
        chk("pre_reset_wen", mem_write_enable, 1);
        chk("pre_reset_addr", mem_address, 32'h54);
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", mem_write_enable, 0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mark = wlog.size();
        for (int i = 0; i < 3; i++) step(x, -1);
        chk("no_write_after_reset", wlog.size() - mark, 0);
        chk("discarded_word", dmem[21], 32'hC0DE0015);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            x = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0);
            step(x, -1);
        end
        idle(DEPTH + 2);
        for (int i = 0; i < 128; i++) chk($sformatf("final_word%0d", i), dmem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
